base_r_tx_encoder: RTL

Transmit-side 64b/66b encoder for the BASE-R path. It consumes the 64-bit data / 8-bit control MII stream produced by the frame generator and classifies each beat. It runs the Clause 49 transmit state machine and emits one registered 66-bit block per accepted beat to the downstream scrambler/gearbox stage. Illegal sequences are replaced by error blocks and, optionally, counted.

---
 rtl/base_r_pkg.sv | 84 ++++++++
 rtl/base_r_tx_classifier.sv | 50 +++++
 rtl/base_r_tx_encoder.sv | 106 ++++++++++
 3 files changed

// File: rtl/base_r_pkg.sv
// Shared constants, types and block-packing helpers for the BASE-R
// 64b/66b transmit path.
package base_r_pkg;

    localparam logic [1:0] SYNC_DATA = 2'b01;
    localparam logic [1:0] SYNC_CTRL = 2'b10;

    localparam logic [7:0] BT_C  = 8'h1E;
    localparam logic [7:0] BT_S  = 8'h78;
    localparam logic [7:0] BT_T0 = 8'h87;
    localparam logic [7:0] BT_T1 = 8'h99;
    localparam logic [7:0] BT_T2 = 8'hAA;
    localparam logic [7:0] BT_T3 = 8'hB4;
    localparam logic [7:0] BT_T4 = 8'hCC;
    localparam logic [7:0] BT_T5 = 8'hD2;
    localparam logic [7:0] BT_T6 = 8'hE1;
    localparam logic [7:0] BT_T7 = 8'hFF;

    localparam logic [7:0] MII_IDLE  = 8'h07;
    localparam logic [7:0] MII_ERROR = 8'hFE;
    localparam logic [7:0] MII_START = 8'hFB;
    localparam logic [7:0] MII_TERM  = 8'hFD;

    localparam logic [6:0] CC_IDLE  = 7'h00;
    localparam logic [6:0] CC_ERROR = 7'h1E;

    localparam logic [65:0] IDLE_BLOCK = {56'h0, BT_C, SYNC_CTRL};
    localparam logic [65:0] ERR_BLOCK  = {{8{CC_ERROR}}, BT_C, SYNC_CTRL};

    typedef enum logic [2:0] {
        ST_INIT, ST_C, ST_D, ST_T, ST_E
    } tx_state_e;

    typedef enum logic [2:0] {
        BEAT_C, BEAT_S, BEAT_D, BEAT_T, BEAT_E
    } beat_cls_e;

    typedef struct packed {
        beat_cls_e   cls;
        logic [2:0]  lane;
    } beat_t;

    function automatic logic [7:0] t_type(input logic [2:0] k);
        logic [7:0] t;
        unique case (k)
            3'd0: t = BT_T0;
            3'd1: t = BT_T1;
            3'd2: t = BT_T2;
            3'd3: t = BT_T3;
            3'd4: t = BT_T4;
            3'd5: t = BT_T5;
            3'd6: t = BT_T6;
            3'd7: t = BT_T7;
        endcase
        return t;
    endfunction

    function automatic logic [6:0] ctrl_code(input logic [7:0] ch);
        return (ch == MII_ERROR) ? CC_ERROR : CC_IDLE;
    endfunction

    function automatic logic [55:0] c_payload(input logic [63:0] d);
        logic [55:0] p;
        p = '0;
        for (int i = 0; i < 8; i++)
            p[7*i +: 7] = ctrl_code(d[8*i +: 8]);
        return p;
    endfunction

    // Pad plus earlier data bytes always sum so C(j) lands at bit 7*j.
    function automatic logic [55:0] t_payload(input logic [63:0] d,
                                              input logic [2:0]  k);
        logic [55:0] p;
        p = '0;
        for (int i = 0; i < 7; i++)
            if (3'(i) < k)
                p[8*i +: 8] = d[8*i +: 8];
        for (int j = 1; j < 8; j++)
            if (3'(j) > k)
                p[7*j +: 7] = ctrl_code(d[8*j +: 8]);
        return p;
    endfunction

endpackage

// File: rtl/base_r_tx_classifier.sv
// Combinational MII beat classifier: C / S / D / T_k / E plus the
// terminate lane.
module base_r_tx_classifier
    import base_r_pkg::*;
(
    input  logic [63:0] tx_data,
    input  logic [7:0]  tx_ctrl,
    output beat_t       beat
);

    logic [7:0] is_ic;
    logic [7:0] t_hit;
    logic [2:0] lane;

    for (genvar k = 0; k < 8; k++) begin : g_lane
        localparam logic [7:0] CMASK = 8'hFF << k;
        localparam logic [7:0] LOW   = ~CMASK | (8'h01 << k);

        assign is_ic[k] = (tx_data[8*k +: 8] == MII_IDLE) ||
                          (tx_data[8*k +: 8] == MII_ERROR);
        assign t_hit[k] = (tx_ctrl == CMASK) &&
                          (tx_data[8*k +: 8] == MII_TERM) &&
                          (&(is_ic | LOW));
    end

    always_comb begin
        lane = 3'd0;
        for (int k = 0; k < 8; k++)
            if (t_hit[k])
                lane = 3'(k);
    end

    always_comb begin
        beat.lane = lane;
        beat.cls  = BEAT_E;
        unique case (1'b1)
            (tx_ctrl == 8'hFF) && (&is_ic):
                beat.cls = BEAT_C;
            (tx_ctrl == 8'h01) && (tx_data[7:0] == MII_START):
                beat.cls = BEAT_S;
            (tx_ctrl == 8'h00):
                beat.cls = BEAT_D;
            (|t_hit):
                beat.cls = BEAT_T;
            default:
                beat.cls = BEAT_E;
        endcase
    end

endmodule

// File: rtl/base_r_tx_encoder.sv
// BASE-R 64b/66b transmit encoder with registered block output.
// Define BASE_R_ENC_ERR_CNT_EN to build the saturating error counter.
module base_r_tx_encoder
    import base_r_pkg::*;
#(
    parameter int DATA_WIDTH  = 64,
    parameter int CTRL_WIDTH  = DATA_WIDTH/8,
    parameter int BLOCK_WIDTH = DATA_WIDTH+2
) (
    input  logic                   clk,
    input  logic                   i_rst,
    input  logic                   i_valid,
    input  logic [DATA_WIDTH-1:0]  i_tx_data,
    input  logic [CTRL_WIDTH-1:0]  i_tx_ctrl,
    output logic                   o_valid,
    output logic [BLOCK_WIDTH-1:0] o_tx_block,
    output logic [15:0]            o_err_count
);

    beat_t            beat;
    beat_cls_e        emit;
    tx_state_e        state_q;
    tx_state_e        state_d;
    logic [65:0]      blk_d;

    base_r_tx_classifier u_cls (
        .tx_data (i_tx_data),
        .tx_ctrl (i_tx_ctrl),
        .beat    (beat)
    );

    always_comb begin
        state_d = ST_E;
        emit    = BEAT_E;
        unique case (state_q)
            ST_D: begin
                if (beat.cls == BEAT_D) begin
                    state_d = ST_D;
                    emit    = BEAT_D;
                end else if (beat.cls == BEAT_T) begin
                    state_d = ST_T;
                    emit    = BEAT_T;
                end
            end
            ST_E: begin
                unique case (beat.cls)
                    BEAT_C:  begin state_d = ST_C; emit = BEAT_C; end
                    BEAT_D:  begin state_d = ST_D; emit = BEAT_D; end
                    BEAT_T:  begin state_d = ST_T; emit = BEAT_T; end
                    default: begin state_d = ST_E; emit = BEAT_E; end
                endcase
            end
            default: begin
                if (beat.cls == BEAT_C) begin
                    state_d = ST_C;
                    emit    = BEAT_C;
                end else if (beat.cls == BEAT_S) begin
                    state_d = ST_D;
                    emit    = BEAT_S;
                end
            end
        endcase
    end

    always_comb begin
        blk_d = ERR_BLOCK;
        unique case (emit)
            BEAT_D: blk_d = {i_tx_data, SYNC_DATA};
            BEAT_C: blk_d = {c_payload(i_tx_data), BT_C, SYNC_CTRL};
            BEAT_S: blk_d = {i_tx_data[63:8], BT_S, SYNC_CTRL};
            BEAT_T: blk_d = {t_payload(i_tx_data, beat.lane),
                             t_type(beat.lane), SYNC_CTRL};
            default: blk_d = ERR_BLOCK;
        endcase
    end

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= ST_INIT;
            o_valid    <= 1'b0;
            o_tx_block <= IDLE_BLOCK;
        end else begin
            o_valid <= i_valid;
            if (i_valid) begin
                state_q    <= state_d;
                o_tx_block <= blk_d;
            end
        end
    end

`ifdef BASE_R_ENC_ERR_CNT_EN
    logic [15:0] err_cnt;

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst)
            err_cnt <= 16'd0;
        else if (i_valid && emit == BEAT_E && err_cnt != 16'hFFFF)
            err_cnt <= err_cnt + 16'd1;
    end

    assign o_err_count = err_cnt;
`else
    assign o_err_count = 16'd0;
`endif

endmodule
